// File: rtl/vx_tag_flush_pkg.sv
// Shared cache flush definitions: controller state encodings and line-geometry helpers.
`timescale 1ns/1ps
package vx_tag_flush_pkg;

    // Registered 2-bit phase; the INIT state is the SWEEP phase with src = auto.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_DRAIN = 2'd1,
        PH_SWEEP = 2'd2,
        PH_DONE  = 2'd3
    } flush_phase_e;

    typedef enum logic {
        SRC_AUTO = 1'b0,
        SRC_REQ  = 1'b1
    } flush_src_e;

    // Logical state as seen by a debugger (phase + src decoded).
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SWEEP = 3'd3,
        ST_DONE  = 3'd4
    } flush_state_e;

    function automatic flush_state_e flush_state(input flush_phase_e ph, input flush_src_e src);
        case (ph)
            PH_IDLE:  return ST_IDLE;
            PH_DRAIN: return ST_DRAIN;
            PH_SWEEP: return (src == SRC_AUTO) ? ST_INIT : ST_SWEEP;
            default:  return ST_DONE;
        endcase
    endfunction

    function automatic int lines_per_bank(input int cache_size, input int line_size, input int num_banks);
        return cache_size / (line_size * num_banks);
    endfunction

    function automatic int line_select_bits(input int lines);
        return (lines > 1) ? $clog2(lines) : 0;
    endfunction

    // Word-address width minus the in-line offset, never below one bit.
    function automatic int line_addr_width(input int word_size, input int line_size);
        int w;
        w = word_size * 8 - $clog2(line_size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vx_tag_flush_ctrl.sv
// Per-bank tag-store flush controller: sweeps every line after reset and on
// each cache-level flush request, after outstanding misses have drained.
`timescale 1ns/1ps
module vx_tag_flush_ctrl
    import vx_tag_flush_pkg::*;
#(
    parameter int CACHE_ID        = 0,
    parameter int BANK_ID         = 0,
    parameter int CACHE_SIZE      = 1,
    parameter int CACHE_LINE_SIZE = 1,
    parameter int NUM_BANKS       = 1,
    parameter int WORD_SIZE       = 1,
    parameter int FLUSH_ON_RESET  = 1,
    localparam int LINE_ADDR_WIDTH = line_addr_width(WORD_SIZE, CACHE_LINE_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush_req_valid,
    output logic                       flush_req_ready,
    output logic                       flush_rsp_valid,
    input  logic                       flush_rsp_ready,
    input  logic                       mshr_empty,
    output logic                       flush_valid,
    input  logic                       flush_ready,
    output logic [LINE_ADDR_WIDTH-1:0] flush_addr,
    output logic                       busy
);

    localparam int LINES    = lines_per_bank(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
    localparam int SEL_BITS = line_select_bits(LINES);
    localparam int CNT_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINES - 1);
    localparam bit AUTO = (FLUSH_ON_RESET != 0);

    // Reject geometries the counter/address mapping cannot represent.
    if (LINES < 1 || LINE_ADDR_WIDTH < SEL_BITS || BANK_ID < 0 ||
        BANK_ID >= NUM_BANKS || CACHE_ID < 0) begin : g_bad_cfg
        $error("vx_tag_flush_ctrl: invalid cache geometry or ids");
    end

    flush_phase_e     phase;
    flush_src_e       src;
    logic [CNT_W-1:0] cnt;
    logic             fire;

    // Address only depends on the counter register, so it holds whenever no fire occurs.
    assign flush_addr = LINE_ADDR_WIDTH'(cnt);
    assign fire       = flush_valid && flush_ready && !stall;

    // Flush FSM with registered handshake outputs; async reset restarts any sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase           <= AUTO ? PH_SWEEP : PH_IDLE;
            src             <= SRC_AUTO;
            cnt             <= '0;
            flush_valid     <= AUTO;
            busy            <= AUTO;
            flush_req_ready <= !AUTO;
            flush_rsp_valid <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (flush_req_valid) begin
                        src             <= SRC_REQ;
                        phase           <= PH_DRAIN;
                        flush_req_ready <= 1'b0;
                        busy            <= 1'b1;
                    end
                end
                PH_DRAIN: begin
                    if (mshr_empty) begin
                        phase       <= PH_SWEEP;
                        flush_valid <= 1'b1;
                    end
                end
                PH_SWEEP: begin
                    if (fire) begin
                        if (cnt == LAST) begin
                            cnt         <= '0;
                            flush_valid <= 1'b0;
                            busy        <= 1'b0;
                            if (src == SRC_AUTO) begin
                                phase           <= PH_IDLE;
                                flush_req_ready <= 1'b1;
                            end else begin
                                phase           <= PH_DONE;
                                flush_rsp_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                PH_DONE: begin
                    if (flush_rsp_ready) begin
                        phase           <= PH_IDLE;
                        flush_rsp_valid <= 1'b0;
                        flush_req_ready <= 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_tag_flush_ctrl.sv
// Scoreboard bench for vx_tag_flush_ctrl: 16-line bank, one instance with
// flush-on-reset and one without.
`timescale 1ns/1ps
module tb_vx_tag_flush_ctrl;

    localparam int LAW = 26;   // 32-bit words, 64-byte lines

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // instance A: FLUSH_ON_RESET=1, instance B: FLUSH_ON_RESET=0
    logic rst_a, stall_a, rqv_a, rqr_a, rsv_a, rsr_a, me_a, fv_a, fr_a, busy_a;
    logic rst_b, stall_b, rqv_b, rqr_b, rsv_b, rsr_b, me_b, fv_b, fr_b, busy_b;
    logic [LAW-1:0] fa_a, fa_b;

    int aq_a[$], aq_b[$];   // expected fire addresses
    int rq_a[$], rq_b[$];   // expected cycle of first rsp_valid
    logic prv_a = 1'b0, prv_b = 1'b0;

    vx_tag_flush_ctrl #(.CACHE_ID(0), .BANK_ID(0), .CACHE_SIZE(1024), .CACHE_LINE_SIZE(64),
                        .NUM_BANKS(1), .WORD_SIZE(4), .FLUSH_ON_RESET(1)) dut_a (
        .clk(clk), .reset(rst_a), .stall(stall_a),
        .flush_req_valid(rqv_a), .flush_req_ready(rqr_a),
        .flush_rsp_valid(rsv_a), .flush_rsp_ready(rsr_a),
        .mshr_empty(me_a), .flush_valid(fv_a), .flush_ready(fr_a),
        .flush_addr(fa_a), .busy(busy_a));

    vx_tag_flush_ctrl #(.CACHE_ID(0), .BANK_ID(0), .CACHE_SIZE(1024), .CACHE_LINE_SIZE(64),
                        .NUM_BANKS(1), .WORD_SIZE(4), .FLUSH_ON_RESET(0)) dut_b (
        .clk(clk), .reset(rst_b), .stall(stall_b),
        .flush_req_valid(rqv_b), .flush_req_ready(rqr_b),
        .flush_rsp_valid(rsv_b), .flush_rsp_ready(rsr_b),
        .mshr_empty(me_b), .flush_valid(fv_b), .flush_ready(fr_b),
        .flush_addr(fa_b), .busy(busy_b));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm, input int act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d with nothing expected (t=%0t)", nm, act, $time);
    endtask

    // Monitors: every fire and every rising rsp_valid is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_a && fv_a && fr_a && !stall_a) begin
            if (aq_a.size() == 0) fail("a_extra_fire", int'(fa_a));
            else check("a_fire_addr", 32'(fa_a), aq_a.pop_front());
        end
        if (rsv_a && !prv_a) begin
            if (rq_a.size() == 0) fail("a_extra_rsp", cyc);
            else check("a_rsp_cycle", cyc, rq_a.pop_front());
        end
        prv_a = rsv_a;
    end

    always @(negedge clk) begin
        if (rst_b && fv_b && fr_b && !stall_b) begin
            if (aq_b.size() == 0) fail("b_extra_fire", int'(fa_b));
            else check("b_fire_addr", 32'(fa_b), aq_b.pop_front());
        end
        if (rsv_b && !prv_b) begin
            if (rq_b.size() == 0) fail("b_extra_rsp", cyc);
            else check("b_rsp_cycle", cyc, rq_b.pop_front());
        end
        prv_b = rsv_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_addrs(input bit b, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (b) aq_b.push_back(i);
            else   aq_a.push_back(i);
        end
    endtask

    // Issue a request from IDLE; off > 0 schedules the response off cycles after the accept cycle.
    task automatic req(input bit b, input int off);
        if (b) rqv_b = 1'b1; else rqv_a = 1'b1;
        @(negedge clk);
        check(b ? "b_req_ready" : "a_req_ready", b ? rqr_b : rqr_a, 1);
        if (off > 0) begin
            if (b) rq_b.push_back(cyc + off);
            else   rq_a.push_back(cyc + off);
        end
        tick();
        if (b) rqv_b = 1'b0; else rqv_a = 1'b0;
    endtask

    task automatic wait_addr(input bit b, input int a);
        for (int i = 0; i < 60; i++) begin
            if (b ? (fv_b && 32'(fa_b) == a) : (fv_a && 32'(fa_a) == a)) return;
            tick();
        end
        fail("wait_addr_timeout", a);
    endtask

    task automatic wait_rsp(input bit b);
        for (int i = 0; i < 80; i++) begin
            if (b ? rsv_b : rsv_a) return;
            tick();
        end
        fail("wait_rsp_timeout", cyc);
    endtask

    task automatic ack(input bit b);
        if (b) rsr_b = 1'b1; else rsr_a = 1'b1;
        tick();
        if (b) rsr_b = 1'b0; else rsr_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 0; stall_a = 0; rqv_a = 0; rsr_a = 0; me_a = 1; fr_a = 1;
        rst_b = 0; stall_b = 0; rqv_b = 0; rsr_b = 0; me_b = 1; fr_b = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_rst_fv", fv_a, 1);   check("a_rst_busy", busy_a, 1);
        check("a_rst_rqr", rqr_a, 0); check("a_rst_rsv", rsv_a, 0);
        check("a_rst_addr", 32'(fa_a), 0);
        check("b_rst_fv", fv_b, 0);   check("b_rst_busy", busy_b, 0);
        check("b_rst_rqr", rqr_b, 1); check("b_rst_rsv", rsv_b, 0);

        // auto sweep after reset release: lines 0..15 back to back, no response
        push_addrs(0, 0, 15);
        tick();
        rst_a = 1; rst_b = 1;
        repeat (15) tick();
        check("a_auto_last_addr", 32'(fa_a), 15);
        check("a_auto_busy_last", busy_a, 1);
        tick();
        check("a_auto_busy_end", busy_a, 0);
        check("a_auto_fv_end", fv_a, 0);
        check("a_auto_rqr_end", rqr_a, 1);
        check("a_auto_q_empty", aq_a.size(), 0);

        // requested flush, misses already drained: response 18 cycles after accept
        push_addrs(0, 0, 15);
        req(0, 18);
        check("a_drain_fv", fv_a, 0);
        check("a_drain_busy", busy_a, 1);
        wait_rsp(0);
        repeat (3) begin
            tick();
            check("a_rsp_held", rsv_a, 1);
            check("a_done_busy", busy_a, 0);
            check("a_done_rqr", rqr_a, 0);
        end
        ack(0);
        check("a_rsp_cleared", rsv_a, 0);
        check("a_idle_rqr", rqr_a, 1);

        // misses outstanding for 5 cycles: no strobe, stays busy
        me_a = 0;
        req(0, 0);
        for (int i = 0; i < 5; i++) begin
            check("a_wait_fv", fv_a, 0);
            check("a_wait_busy", busy_a, 1);
            tick();
        end
        me_a = 1;
        check("a_drain_last_fv", fv_a, 0);
        rq_a.push_back(cyc + 17);
        push_addrs(0, 0, 15);
        tick();
        check("a_sweep_start_fv", fv_a, 1);
        check("a_sweep_start_addr", 32'(fa_a), 0);
        wait_rsp(0);
        ack(0);

        // back-pressure: flush_ready low at line 7 for 3 cycles, stall at line 9 for 2
        push_addrs(0, 0, 15);
        req(0, 23);
        wait_addr(0, 7);
        fr_a = 0;
        repeat (2) begin
            tick();
            check("a_hold7_addr", 32'(fa_a), 7);
            check("a_hold7_fv", fv_a, 1);
        end
        tick();
        fr_a = 1;
        wait_addr(0, 9);
        stall_a = 1;
        tick();
        check("a_hold9_addr", 32'(fa_a), 9);
        tick();
        stall_a = 0;
        wait_rsp(0);
        ack(0);
        check("a_bp_q_empty", aq_a.size(), 0);

        // reset at line 10 of a requested sweep: abort, no response, auto sweep repeats
        push_addrs(0, 0, 9);
        req(0, 0);
        wait_addr(0, 10);
        rst_a = 0;
        #1;
        check("a_abort_addr", 32'(fa_a), 0);
        check("a_abort_fv", fv_a, 1);
        check("a_abort_busy", busy_a, 1);
        check("a_abort_rsv", rsv_a, 0);
        check("a_abort_rqr", rqr_a, 0);
        push_addrs(0, 0, 15);
        tick();
        rst_a = 1;
        repeat (16) tick();
        check("a_resweep_busy", busy_a, 0);
        repeat (3) tick();
        check("a_resweep_rsv", rsv_a, 0);
        check("a_final_q_empty", aq_a.size(), 0);
        check("a_final_rq_empty", rq_a.size(), 0);

        // no flush on reset; second request held off until the first response is taken
        push_addrs(1, 0, 15);
        req(1, 18);
        wait_addr(1, 3);
        rqv_b = 1;
        #1;
        check("b_sweep_rqr", rqr_b, 0);
        wait_rsp(1);
        repeat (2) begin
            tick();
            check("b_done_rqr", rqr_b, 0);
        end
        rq_b.push_back(cyc + 19);
        push_addrs(1, 0, 15);
        ack(1);
        check("b_second_accept", rqr_b, 1);
        tick();
        rqv_b = 0;
        check("b_second_busy", busy_b, 1);
        wait_rsp(1);
        ack(1);
        check("b_final_rqr", rqr_b, 1);
        check("b_final_q_empty", aq_b.size(), 0);
        check("b_final_rq_empty", rq_b.size(), 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_tag_flush_ctrl.md
Name: VX_tag_flush_ctrl

Overview:
Per-bank controller that sits directly upstream of the bank's tag store and drives its flush port. It invalidates every line of the bank after reset and on each cache-level flush request. It waits for outstanding misses to drain before sweeping, then walks all line indices one per granted cycle. While the controller is busy, the bank arbiter blocks core lookups.

Parameters:
CACHE_ID, 0, cache instance id (debug trace only)
BANK_ID, 0, bank index (debug trace only)
CACHE_SIZE, 1, cache size in bytes
CACHE_LINE_SIZE, 1, line size in bytes
NUM_BANKS, 1, number of banks
WORD_SIZE, 1, word size in bytes (used for LINE_ADDR_WIDTH derivation)
FLUSH_ON_RESET, 1, 1 = run an automatic sweep after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  bank pipeline stall; no line advance while high
flush_req_valid  in  1  cache-level flush request
flush_req_ready  out  1  request accepted (high only in IDLE)
flush_rsp_valid  out  1  requested flush complete; held until accepted
flush_rsp_ready  in  1  response consumed
mshr_empty  in  1  no outstanding misses in this bank
flush_valid  out  1  drives tag store flush strobe
flush_ready  in  1  arbiter grants the tag-store slot this cycle
flush_addr  out  LINE_ADDR_WIDTH  line address; low LINE_SELECT_BITS = counter, upper bits 0
busy  out  1  block core lookups (high in INIT, DRAIN, SWEEP)

Behaviour:
- LINES_PER_BANK = CACHE_SIZE/(CACHE_LINE_SIZE*NUM_BANKS). Counter width is max(1, LINE_SELECT_BITS).
- States: INIT, IDLE, DRAIN, SWEEP, DONE. State is registered, 2-bit encoded, with an additional 1-bit src flag (auto vs requested).
- Reset asserted (async): state = INIT if FLUSH_ON_RESET else IDLE; counter = 0; src = auto; flush_valid = FLUSH_ON_RESET; busy = FLUSH_ON_RESET; flush_req_ready = !FLUSH_ON_RESET; flush_rsp_valid = 0.
- INIT: flush_valid = 1, flush_addr = counter. The counter advances on a fire, where fire = flush_valid && flush_ready && !stall. On fire at counter == LINES_PER_BANK-1: counter <= 0, go to IDLE, no response.
- IDLE: flush_req_ready = 1, busy = 0. On flush_req_valid: src = requested, go to DRAIN.
- DRAIN: busy = 1, flush_valid = 0. When mshr_empty = 1, go to SWEEP on the next edge. If mshr_empty is already 1 on entry, DRAIN lasts exactly 1 cycle.
- SWEEP: same as INIT. On the last-line fire: counter <= 0, go to DONE.
- DONE: flush_rsp_valid = 1, busy = 0. On flush_rsp_ready: go to IDLE. A new request is not accepted until IDLE.
- Latency: a requested flush with mshr_empty = 1 and flush_ready = 1, stall = 0 gives rsp_valid exactly LINES_PER_BANK+2 cycles after the accept edge (1 DRAIN cycle + N sweep cycles + 1).
- flush_ready low or stall high: hold flush_valid and flush_addr stable, do not advance the counter. No line is skipped or repeated.
- LINES_PER_BANK = 1: the sweep is exactly one fire. The 1-bit counter stays 0.
- Reset asserted mid-sweep or mid-DRAIN: abort immediately, restart per the reset rules. No response is produced for the aborted request.
- flush_req_valid while not IDLE: ignored (ready = 0). The requester holds the request.
- flush_valid and flush_addr come directly from registered state and counter (no combinational path from flush_ready).

Decomposition:
- Shared cache define header/package: state enum (INIT, IDLE, DRAIN, SWEEP, DONE) and LINES_PER_BANK/LINE_SELECT_BITS macros, reused from the existing cache defines.
- No sub-module. The FSM and counter live in one module. An optional DBG_TRACE_CACHE_TAG trace prints each fire with BANK_ID and the line index.

Test Plan:
Config for all scenarios: CACHE_SIZE=1024, CACHE_LINE_SIZE=64, NUM_BANKS=1, so 16 lines.
- Reset release, FLUSH_ON_RESET=1, flush_ready=1, stall=0 -> flush_addr 0..15 on 16 consecutive cycles; busy falls the cycle after addr 15; flush_rsp_valid never asserts.
- In IDLE: pulse flush_req_valid, mshr_empty=1 -> req_ready high on the accept cycle; 1 DRAIN cycle; addrs 0..15; rsp_valid at accept+18 and held until rsp_ready.
- Request with mshr_empty=0 for 5 cycles -> flush_valid stays 0 and busy stays 1 for those cycles; the sweep starts the cycle after mshr_empty rises.
- During SWEEP: flush_ready=0 at addr 7 for 3 cycles, then stall=1 at addr 9 for 2 cycles -> addr holds 7 then 9; every index 0..15 fires exactly once.
- Assert reset while counter=10 in SWEEP -> next cycle state=INIT, counter=0, no rsp; after release the full auto sweep 0..15 repeats.
- FLUSH_ON_RESET=0 -> after reset busy=0 and req_ready=1 immediately; a second request during SWEEP is not accepted until after rsp_ready.
